// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between NUM_REQ byte
// sources, with bounded bursts, an enforced idle gap and a done watchdog.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 4,
  parameter int GAP_CYCLES     = 435,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [8*NUM_REQ-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [7:0]                 uart_data_o,
  output logic                       uart_start_o,
  input  logic                       uart_done_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       timeout_err_o,
  output logic [15:0]                frames_sent_o
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(MAX_BURST) + 1;

  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD     = TW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LAST   = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      data_q, data_d;
  logic            start_q, start_d;
  logic            timeout_q, timeout_d;
  logic [15:0]     frames_q, frames_d;
  logic            done_q;
  logic            done_rise;
  logic [NUM_REQ-1:0] ready_c;

  logic [7:0]      req_byte [NUM_REQ];
  logic            arb_found;
  logic [IW-1:0]   arb_win;
  logic [IW-1:0]   arb_cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = req_data_i[8*g +: 8];
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  assign done_rise = uart_done_i & ~done_q;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    timer_d   = timer_q;
    data_d    = data_q;
    frames_d  = frames_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    ready_c   = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          ready_c[arb_win] = 1'b1;
          data_d           = req_byte[arb_win];
          grant_d          = arb_win;
          burst_d          = '0;
          start_d          = 1'b1;
          state_d          = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = TIMEOUT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the very last watchdog cycle still counts as success.
        if (done_rise) begin
          frames_d = frames_q + 16'd1;
          timer_d  = GAP_LOAD;
          state_d  = S_GAP;
        end else if (timer_q == '0) begin
          timeout_d = 1'b1;
          rr_ptr_d  = next_idx(grant_q);
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (req_valid_i[grant_q] && (burst_q < BURST_LAST)) begin
          ready_c[grant_q] = 1'b1;
          data_d           = req_byte[grant_q];
          burst_d          = burst_q + 1'b1;
          start_d          = 1'b1;
          state_d          = S_LAUNCH;
        end else begin
          rr_ptr_d = next_idx(grant_q);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      burst_q   <= '0;
      timer_q   <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      frames_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      frames_q  <= frames_d;
      done_q    <= uart_done_i;
    end
  end

  // No byte may be consumed while reset is held, even with requests pending.
  assign req_ready_o   = reset ? '0 : ready_c;
  assign uart_data_o   = data_q;
  assign uart_start_o  = start_q;
  assign busy_o        = (state_q != S_IDLE);
  assign grant_id_o    = grant_q;
  assign timeout_err_o = timeout_q;
  assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: randomized requesters and transmitter,
// frame-level reference model, decoupled monitor on start/timeout/frame count.
module tb_uart_tx_scheduler;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int G  = 12;
  localparam int T  = 64;

  localparam int P_IDLE  = 0;
  localparam int P_FRAME = 1;
  localparam int P_GAP   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic [7:0]       uart_data;
  logic             uart_start;
  logic             uart_done = 1'b0;
  logic             busy;
  logic [1:0]       grant_id;
  logic             timeout_err;
  logic [15:0]      frames_sent;

  uart_tx_scheduler #(
    .NUM_REQ(N), .MAX_BURST(MB), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .uart_data_o(uart_data), .uart_start_o(uart_start), .uart_done_i(uart_done),
    .busy_o(busy), .grant_id_o(grant_id), .timeout_err_o(timeout_err),
    .frames_sent_o(frames_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int id; logic [7:0] data; } start_t;
  typedef struct { int cyc; int frames; } cnt_t;
  typedef logic [7:0] byteq_t[$];

  start_t sq[$];
  cnt_t   tq[$];
  cnt_t   fq[$];
  byteq_t rq [N];

  int total = 0;
  int bad   = 0;

  // reference model of the scheduler at frame granularity
  int m_phase = P_IDLE, m_rr = 0, m_owner = 0, m_burst = 0;
  int m_start = 0, m_decide = 0, m_frames = 0;

  // transmitter and producer model
  logic done_drv = 1'b0, done_prev = 1'b0;
  int   tx_fall = -1, tx_rise = -1, tx_mode = 0, tx_fixed = 40, prod_rate = 0;
  logic saw_start = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int pick_len();
    int r;
    case (tx_mode)
      0: return int'($urandom_range(2, 20));
      1: return tx_fixed;
      2: return -1;
      default: begin
        r = int'($urandom_range(0, 9));
        if (r == 0) return T;
        if (r == 1) return T + 1;
        if (r == 2) return -1;
        return int'($urandom_range(2, 30));
      end
    endcase
  endfunction

  task automatic do_grant(input int w, input int b, input int c, output logic [N-1:0] e);
    e       = '0;
    e[w]    = 1'b1;
    m_owner = w;
    m_burst = b;
    sq.push_back('{cyc: c + 1, id: w, data: rq[w][0]});
    m_phase = P_FRAME;
    m_start = c + 1;
  endtask

  task automatic step();
    int c, w;
    logic rose;
    logic [N-1:0] v, e;
    @(negedge clk);
    c = cyc;
    if (prod_rate > 0 && int'($urandom_range(0, 99)) < prod_rate) begin
      w = int'($urandom_range(0, N - 1));
      if (rq[w].size() < 6) rq[w].push_back(8'($urandom));
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rq[i].size() != 0);
      req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
    end
    if (c == tx_fall) done_drv = 1'b0;
    if (c == tx_rise) done_drv = 1'b1;
    uart_done = done_drv;
    rose      = done_drv && !done_prev;
    done_prev = done_drv;
    v = req_valid;
    #1;
    e = '0;
    case (m_phase)
      P_IDLE: begin
        if (v != '0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
          do_grant(w, 0, c, e);
        end
      end
      P_FRAME: begin
        if (c > m_start) begin
          if (rose) begin
            m_frames = (m_frames + 1) % 65536;
            fq.push_back('{cyc: c + 1, frames: m_frames});
            m_decide = c + G;
            m_phase  = P_GAP;
          end else if (c == m_start + T) begin
            tq.push_back('{cyc: c + 1, frames: m_frames});
            m_rr    = (m_owner + 1) % N;
            m_phase = P_IDLE;
          end
        end
      end
      default: begin
        if (c == m_decide) begin
          if (v[m_owner] && m_burst < MB - 1) do_grant(m_owner, m_burst + 1, c, e);
          else begin
            m_rr    = (m_owner + 1) % N;
            m_phase = P_IDLE;
          end
        end
      end
    endcase
    total++;
    if (req_ready !== e) begin
      bad++;
      $display("FAIL req_ready cycle %0d: got %b expected %b", c, req_ready, e);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1 && rq[i].size() != 0) void'(rq[i].pop_front());
    saw_start = (uart_start === 1'b1);
    if (saw_start) begin
      tx_fall = c + 1;
      w       = pick_len();
      tx_rise = (w < 0) ? -1 : c + w;
    end
  endtask

  task automatic run_quiet(input string nm, input int max);
    int n;
    bit quiet;
    n = 0;
    do begin
      step();
      n++;
      quiet = (m_phase == P_IDLE) && (sq.size() == 0) && (tq.size() == 0) && (fq.size() == 0);
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) quiet = 0;
    end while (!quiet && n < max);
    chk({nm, " drained within budget"}, quiet, 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("reset req_ready", req_ready, 0);
    chk("reset uart_start", uart_start, 0);
    chk("reset uart_data", uart_data, 0);
    chk("reset busy", busy, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset frames_sent", frames_sent, 0);
    sq.delete(); tq.delete(); fq.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    m_phase = P_IDLE; m_rr = 0; m_frames = 0; m_owner = 0; m_burst = 0;
    done_drv = 1'b0; done_prev = 1'b0; uart_done = 1'b0;
    tx_fall = -1; tx_rise = -1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (reset) last_data = 8'h00;
    else begin
      if (uart_start === 1'b1) begin
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL start: unexpected start cycle %0d data %02h", cyc, uart_data);
        end else begin
          if (sq[0].cyc != cyc || uart_data !== sq[0].data || int'(grant_id) != sq[0].id) begin
            bad++;
            $display("FAIL start: cycle %0d data %02h id %0d, expected cycle %0d data %02h id %0d",
                     cyc, uart_data, grant_id, sq[0].cyc, sq[0].data, sq[0].id);
          end
          void'(sq.pop_front());
        end
        last_data = uart_data;
      end else begin
        if (sq.size() != 0 && sq[0].cyc <= cyc) begin
          total++; bad++;
          $display("FAIL start: missing at cycle %0d, expected data %02h id %0d", cyc, sq[0].data, sq[0].id);
          void'(sq.pop_front());
        end
        total++;
        if (uart_data !== last_data) begin
          bad++;
          $display("FAIL uart_data hold: got %02h expected %02h cycle %0d", uart_data, last_data, cyc);
        end
      end
      if (timeout_err === 1'b1) begin
        total++;
        if (tq.size() == 0 || tq[0].cyc != cyc || int'(frames_sent) != tq[0].frames) begin
          bad++;
          $display("FAIL timeout_err: unexpected pulse cycle %0d frames %0d", cyc, frames_sent);
        end
        if (tq.size() != 0) void'(tq.pop_front());
      end else if (tq.size() != 0 && tq[0].cyc <= cyc) begin
        total++; bad++;
        $display("FAIL timeout_err: missing at cycle %0d", cyc);
        void'(tq.pop_front());
      end
      if (fq.size() != 0 && fq[0].cyc <= cyc) begin
        total++;
        if (int'(frames_sent) != fq[0].frames || fq[0].cyc != cyc) begin
          bad++;
          $display("FAIL frames_sent: got %0d expected %0d cycle %0d", frames_sent, fq[0].frames, cyc);
        end
        void'(fq.pop_front());
      end
    end
  end

  initial begin
    int f0, n;
    #1 reset = 1'b1;
    #2;
    chk("por uart_start", uart_start, 0);
    chk("por busy", busy, 0);
    chk("por frames_sent", frames_sent, 0);
    chk("por req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // single byte with a fixed transmitter latency
    rq[0].push_back(8'hA5);
    tx_mode = 1; tx_fixed = 40;
    run_quiet("single", 300);
    chk("single frames_sent", frames_sent, 1);
    chk("single busy after gap", busy, 0);

    // every requester pending: one byte each, then two each
    tx_mode = 0;
    for (int i = 0; i < N; i++) rq[i].push_back(8'($urandom));
    run_quiet("round robin 1", 800);
    for (int i = 0; i < N; i++) begin
      rq[i].push_back(8'($urandom));
      rq[i].push_back(8'($urandom));
    end
    run_quiet("round robin 2", 1500);

    // burst cap on a lone requester
    f0 = m_frames;
    for (int i = 0; i < 6; i++) rq[2].push_back(8'(8'h30 + i));
    run_quiet("burst", 1500);
    chk("burst frames_sent", frames_sent, f0 + 6);

    // watchdog, and the done-on-last-cycle boundary either side
    tx_mode = 2;
    rq[1].push_back(8'h11);
    rq[2].push_back(8'h22);
    run_quiet("timeout", 600);
    tx_mode = 1; tx_fixed = T;
    rq[3].push_back(8'h33);
    run_quiet("done at limit", 300);
    tx_fixed = T + 1;
    rq[0].push_back(8'h44);
    run_quiet("done past limit", 300);

    // randomized traffic
    tx_mode = 3; prod_rate = 15;
    repeat (3000) step();
    prod_rate = 0;
    run_quiet("random", 6000);

    // reset in the middle of a frame
    tx_mode = 2;
    rq[1].push_back(8'h5A);
    n = 0;
    do begin step(); n++; end while (!saw_start && n < 20);
    chk("mid-wait start seen", saw_start, 1);
    repeat (50) step();
    chk("mid-wait busy before reset", busy, 1);
    do_reset();
    tx_mode = 0;
    rq[2].push_back(8'h77);
    rq[0].push_back(8'h66);
    n = 0;
    do begin step(); n++; end while (!saw_start && n < 20);
    chk("post-reset start seen", saw_start, 1);
    chk("post-reset grant", grant_id, 0);
    chk("post-reset data", uart_data, 8'h66);
    run_quiet("post-reset", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
